// File: rtl/udma_ethernet_mc_reg_if.sv
// udma_ethernet_mc_reg_if
// Multi-channel configuration/status register file for the uDMA Ethernet peripheral.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cfg_*_i / cfg_data_o          APB-side register access (combinational read, no wait states)
//   cfg_rx_* / cfg_tx_* outputs   per-channel descriptors and one-cycle en/clr pulses
//   cfg_rx_* / cfg_tx_* inputs    per-channel live state (current address, bytes left, flags)
//   tx_busy_i, status_i, speed_i  MAC status for readback; tx_busy_i also gates TX enables
//   err_i                         MAC error event pulses, captured in sticky W1C bits
//   rx/tx_fcs_i, *_frame_done_i   last FCS values and frame-complete pulses
//   en_rx_o, en_tx_o              MAC enables
//   rx/tx/err_irq_o               registered interrupt levels (pending & enable)
//
// Address map: addr[5]=0 selects channel addr[4:3], offset addr[2:0].
//              addr[5:4]=2'b10 selects the global block, offset addr[3:0].
module udma_ethernet_mc_reg_if #(
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16,
    parameter int unsigned N_CH           = 2,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,

    input  logic [31:0]                    cfg_data_i,
    input  logic [5:0]                     cfg_addr_i,
    input  logic                           cfg_valid_i,
    input  logic                           cfg_rwn_i,
    output logic [31:0]                    cfg_data_o,
    output logic                           cfg_ready_o,

    output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
    output logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_size_o,
    output logic [N_CH-1:0]                cfg_rx_continuous_o,
    output logic [N_CH-1:0]                cfg_rx_en_o,
    output logic [N_CH-1:0]                cfg_rx_clr_o,
    input  logic [N_CH-1:0]                cfg_rx_en_i,
    input  logic [N_CH-1:0]                cfg_rx_pending_i,
    input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,

    output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
    output logic [N_CH*TRANS_SIZE-1:0]     cfg_tx_size_o,
    output logic [N_CH-1:0]                cfg_tx_continuous_o,
    output logic [N_CH-1:0]                cfg_tx_en_o,
    output logic [N_CH-1:0]                cfg_tx_clr_o,
    input  logic [N_CH-1:0]                cfg_tx_en_i,
    input  logic [N_CH-1:0]                cfg_tx_pending_i,
    input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,

    input  logic [N_CH-1:0]                tx_busy_i,
    input  logic [7:0]                     status_i,
    input  logic [5:0]                     err_i,
    input  logic [1:0]                     speed_i,
    input  logic [31:0]                    rx_fcs_i,
    input  logic [31:0]                    tx_fcs_i,
    input  logic                           rx_frame_done_i,
    input  logic                           tx_frame_done_i,

    output logic                           en_rx_o,
    output logic                           en_tx_o,
    output logic                           rx_irq_o,
    output logic                           tx_irq_o,
    output logic                           err_irq_o
);

    localparam int unsigned AW = L2_AWIDTH_NOAL;
    localparam int unsigned TW = TRANS_SIZE;
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    // Global register offsets
    localparam logic [3:0] GStatus  = 4'd0;
    localparam logic [3:0] GSetup   = 4'd1;
    localparam logic [3:0] GError   = 4'd2;
    localparam logic [3:0] GIrqEn   = 4'd3;
    localparam logic [3:0] GIrqPend = 4'd4;
    localparam logic [3:0] GRxFcs   = 4'd5;
    localparam logic [3:0] GTxFcs   = 4'd6;
    localparam logic [3:0] GRxCnt   = 4'd7;
    localparam logic [3:0] GTxCnt   = 4'd8;

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    logic [N_CH*AW-1:0]   rx_saddr_q, rx_saddr_d, tx_saddr_q, tx_saddr_d;
    logic [N_CH*TW-1:0]   rx_size_q, rx_size_d, tx_size_q, tx_size_d;
    logic [N_CH-1:0]      rx_cont_q, rx_cont_d, tx_cont_q, tx_cont_d;
    logic [N_CH-1:0]      rx_en_q, rx_en_d, tx_en_q, tx_en_d;
    logic [N_CH-1:0]      rx_clr_q, rx_clr_d, tx_clr_q, tx_clr_d;
    logic                 en_rx_q, en_rx_d, en_tx_q, en_tx_d;
    logic [5:0]           err_q, err_d;
    logic [2:0]           irq_en_q, irq_en_d;
    logic [2:0]           irq_pend_q, irq_pend_d;
    logic [CNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic                 rx_irq_q, rx_irq_d, tx_irq_q, tx_irq_d, err_irq_q, err_irq_d;

    // ---------------------------------------------------------------------------------------
    // Access decode
    // ---------------------------------------------------------------------------------------
    logic       wr_en;
    logic       chan_sel;
    logic       glb_sel;
    logic [1:0] ch;
    logic [2:0] ch_off;
    logic [3:0] glb_off;
    logic       glb_wr;

    assign wr_en    = cfg_valid_i & ~cfg_rwn_i;
    assign chan_sel = ~cfg_addr_i[5];
    assign glb_sel  = cfg_addr_i[5] & ~cfg_addr_i[4];
    assign ch       = cfg_addr_i[4:3];
    assign ch_off   = cfg_addr_i[2:0];
    assign glb_off  = cfg_addr_i[3:0];
    assign glb_wr   = wr_en & glb_sel;

    logic unused_data;
    assign unused_data = ^cfg_data_i;

    // ---------------------------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------------------------
    logic [5:0] err_clr;
    logic [2:0] pend_clr;
    logic [2:0] pend_set;
    logic       rx_cnt_clr, tx_cnt_clr;

    always_comb begin
        rx_saddr_d = rx_saddr_q;
        tx_saddr_d = tx_saddr_q;
        rx_size_d  = rx_size_q;
        tx_size_d  = tx_size_q;
        rx_cont_d  = rx_cont_q;
        tx_cont_d  = tx_cont_q;
        // Pulses default low so they last exactly one cycle
        rx_en_d    = '0;
        tx_en_d    = '0;
        rx_clr_d   = '0;
        tx_clr_d   = '0;

        if (wr_en && chan_sel) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (ch == 2'(i)) begin
                    case (ch_off)
                        3'd0: rx_saddr_d[i*AW +: AW] = cfg_data_i[AW-1:0];
                        3'd1: rx_size_d[i*TW +: TW]  = cfg_data_i[TW-1:0];
                        3'd2: begin
                            rx_clr_d[i]  = cfg_data_i[6];
                            rx_en_d[i]   = cfg_data_i[4];
                            rx_cont_d[i] = cfg_data_i[0];
                        end
                        3'd3: tx_saddr_d[i*AW +: AW] = cfg_data_i[AW-1:0];
                        3'd4: tx_size_d[i*TW +: TW]  = cfg_data_i[TW-1:0];
                        3'd5: begin
                            tx_clr_d[i]  = cfg_data_i[6];
                            // A busy TX channel must not be restarted
                            tx_en_d[i]   = cfg_data_i[4] & ~tx_busy_i[i];
                            tx_cont_d[i] = cfg_data_i[0];
                        end
                        default: ;
                    endcase
                end
            end
        end

        en_rx_d  = en_rx_q;
        en_tx_d  = en_tx_q;
        irq_en_d = irq_en_q;
        if (glb_wr && glb_off == GSetup) begin
            en_rx_d = cfg_data_i[9];
            en_tx_d = cfg_data_i[8];
        end
        if (glb_wr && glb_off == GIrqEn) begin
            irq_en_d = cfg_data_i[2:0];
        end

        // Sticky bits: clear first, then OR in new events so a coincident event wins
        err_clr    = (glb_wr && glb_off == GError) ? cfg_data_i[5:0] : 6'h0;
        pend_clr   = (glb_wr && glb_off == GIrqPend) ? cfg_data_i[2:0] : 3'h0;
        pend_set   = {tx_frame_done_i, |err_i, rx_frame_done_i};
        err_d      = (err_q & ~err_clr) | err_i;
        irq_pend_d = (irq_pend_q & ~pend_clr) | pend_set;

        // Saturating frame counters; a clear coincident with a done pulse counts that frame
        rx_cnt_clr = glb_wr && glb_off == GRxCnt;
        tx_cnt_clr = glb_wr && glb_off == GTxCnt;
        rx_cnt_d   = rx_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        if (rx_cnt_clr) begin
            rx_cnt_d = CNT_WIDTH'(rx_frame_done_i);
        end else if (rx_frame_done_i && rx_cnt_q != CntMax) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
        end
        if (tx_cnt_clr) begin
            tx_cnt_d = CNT_WIDTH'(tx_frame_done_i);
        end else if (tx_frame_done_i && tx_cnt_q != CntMax) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end

        // Interrupt levels follow the registered pending/enable state one cycle later
        rx_irq_d  = irq_pend_q[0] & irq_en_q[0];
        err_irq_d = irq_pend_q[1] & irq_en_q[1];
        tx_irq_d  = irq_pend_q[2] & irq_en_q[2];
    end

    // ---------------------------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_saddr_q <= '0;
            tx_saddr_q <= '0;
            rx_size_q  <= '0;
            tx_size_q  <= '0;
            rx_cont_q  <= '0;
            tx_cont_q  <= '0;
            rx_en_q    <= '0;
            tx_en_q    <= '0;
            rx_clr_q   <= '0;
            tx_clr_q   <= '0;
            en_rx_q    <= 1'b0;
            en_tx_q    <= 1'b0;
            err_q      <= '0;
            irq_en_q   <= '0;
            irq_pend_q <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            rx_irq_q   <= 1'b0;
            tx_irq_q   <= 1'b0;
            err_irq_q  <= 1'b0;
        end else begin
            rx_saddr_q <= rx_saddr_d;
            tx_saddr_q <= tx_saddr_d;
            rx_size_q  <= rx_size_d;
            tx_size_q  <= tx_size_d;
            rx_cont_q  <= rx_cont_d;
            tx_cont_q  <= tx_cont_d;
            rx_en_q    <= rx_en_d;
            tx_en_q    <= tx_en_d;
            rx_clr_q   <= rx_clr_d;
            tx_clr_q   <= tx_clr_d;
            en_rx_q    <= en_rx_d;
            en_tx_q    <= en_tx_d;
            err_q      <= err_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_irq_q   <= rx_irq_d;
            tx_irq_q   <= tx_irq_d;
            err_irq_q  <= err_irq_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Read mux (combinational, side-effect free)
    // ---------------------------------------------------------------------------------------
    always_comb begin
        cfg_data_o = 32'h0;
        if (chan_sel) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (ch == 2'(i)) begin
                    case (ch_off)
                        3'd0: cfg_data_o = 32'(cfg_rx_curr_addr_i[i*AW +: AW]);
                        3'd1: cfg_data_o = 32'(cfg_rx_bytes_left_i[i*TW +: TW]);
                        3'd2: cfg_data_o = {26'h0, cfg_rx_pending_i[i], cfg_rx_en_i[i], 3'h0,
                                            rx_cont_q[i]};
                        3'd3: cfg_data_o = 32'(cfg_tx_curr_addr_i[i*AW +: AW]);
                        3'd4: cfg_data_o = 32'(cfg_tx_bytes_left_i[i*TW +: TW]);
                        3'd5: cfg_data_o = {26'h0, cfg_tx_pending_i[i], cfg_tx_en_i[i], 3'h0,
                                            tx_cont_q[i]};
                        default: ;
                    endcase
                end
            end
        end else if (glb_sel) begin
            case (glb_off)
                GStatus:  cfg_data_o = {16'h0, 4'(tx_busy_i), 2'h0, speed_i, status_i};
                GSetup:   cfg_data_o = {22'h0, en_rx_q, en_tx_q, 8'h0};
                GError:   cfg_data_o = {26'h0, err_q};
                GIrqEn:   cfg_data_o = {29'h0, irq_en_q};
                GIrqPend: cfg_data_o = {29'h0, irq_pend_q};
                GRxFcs:   cfg_data_o = rx_fcs_i;
                GTxFcs:   cfg_data_o = tx_fcs_i;
                GRxCnt:   cfg_data_o = 32'(rx_cnt_q);
                GTxCnt:   cfg_data_o = 32'(tx_cnt_q);
                default:  ;
            endcase
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    assign cfg_ready_o         = 1'b1;
    assign cfg_rx_startaddr_o  = rx_saddr_q;
    assign cfg_tx_startaddr_o  = tx_saddr_q;
    assign cfg_rx_size_o       = rx_size_q;
    assign cfg_tx_size_o       = tx_size_q;
    assign cfg_rx_continuous_o = rx_cont_q;
    assign cfg_tx_continuous_o = tx_cont_q;
    assign cfg_rx_en_o         = rx_en_q;
    assign cfg_tx_en_o         = tx_en_q;
    assign cfg_rx_clr_o        = rx_clr_q;
    assign cfg_tx_clr_o        = tx_clr_q;
    assign en_rx_o             = en_rx_q;
    assign en_tx_o             = en_tx_q;
    assign rx_irq_o            = rx_irq_q;
    assign tx_irq_o            = tx_irq_q;
    assign err_irq_o           = err_irq_q;

endmodule

// File: tb/tb_udma_ethernet_mc_reg_if.sv
// Directed self-checking bench for udma_ethernet_mc_reg_if (N_CH=2, CNT_WIDTH=4).
module tb_udma_ethernet_mc_reg_if;

    localparam int AW = 12;
    localparam int TW = 16;
    localparam int NC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]      cfg_data_i = '0;
    logic [5:0]       cfg_addr_i = '0;
    logic             cfg_valid_i = 1'b0;
    logic             cfg_rwn_i = 1'b1;
    logic [31:0]      cfg_data_o;
    logic             cfg_ready_o;
    logic [NC*AW-1:0] rx_saddr_o, tx_saddr_o;
    logic [NC*TW-1:0] rx_size_o, tx_size_o;
    logic [NC-1:0]    rx_cont_o, tx_cont_o, rx_en_o, tx_en_o, rx_clr_o, tx_clr_o;
    logic [NC-1:0]    rx_en_i = '0, tx_en_i = '0, rx_pend_i = '0, tx_pend_i = '0;
    logic [NC*AW-1:0] rx_curr_i = '0, tx_curr_i = '0;
    logic [NC*TW-1:0] rx_left_i = '0, tx_left_i = '0;
    logic [NC-1:0]    tx_busy_i = '0;
    logic [7:0]       status_i = 8'hA5;
    logic [5:0]       err_i = '0;
    logic [1:0]       speed_i = 2'b10;
    logic [31:0]      rx_fcs_i = '0, tx_fcs_i = '0;
    logic             rx_done_i = 1'b0, tx_done_i = 1'b0;
    logic             en_rx_o, en_tx_o, rx_irq_o, tx_irq_o, err_irq_o;

    int n_cmp = 0;
    int n_err = 0;

    udma_ethernet_mc_reg_if #(
        .L2_AWIDTH_NOAL(AW),
        .TRANS_SIZE    (TW),
        .N_CH          (NC),
        .CNT_WIDTH     (4)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cfg_data_i         (cfg_data_i),
        .cfg_addr_i         (cfg_addr_i),
        .cfg_valid_i        (cfg_valid_i),
        .cfg_rwn_i          (cfg_rwn_i),
        .cfg_data_o         (cfg_data_o),
        .cfg_ready_o        (cfg_ready_o),
        .cfg_rx_startaddr_o (rx_saddr_o),
        .cfg_rx_size_o      (rx_size_o),
        .cfg_rx_continuous_o(rx_cont_o),
        .cfg_rx_en_o        (rx_en_o),
        .cfg_rx_clr_o       (rx_clr_o),
        .cfg_rx_en_i        (rx_en_i),
        .cfg_rx_pending_i   (rx_pend_i),
        .cfg_rx_curr_addr_i (rx_curr_i),
        .cfg_rx_bytes_left_i(rx_left_i),
        .cfg_tx_startaddr_o (tx_saddr_o),
        .cfg_tx_size_o      (tx_size_o),
        .cfg_tx_continuous_o(tx_cont_o),
        .cfg_tx_en_o        (tx_en_o),
        .cfg_tx_clr_o       (tx_clr_o),
        .cfg_tx_en_i        (tx_en_i),
        .cfg_tx_pending_i   (tx_pend_i),
        .cfg_tx_curr_addr_i (tx_curr_i),
        .cfg_tx_bytes_left_i(tx_left_i),
        .tx_busy_i          (tx_busy_i),
        .status_i           (status_i),
        .err_i              (err_i),
        .speed_i            (speed_i),
        .rx_fcs_i           (rx_fcs_i),
        .tx_fcs_i           (tx_fcs_i),
        .rx_frame_done_i    (rx_done_i),
        .tx_frame_done_i    (tx_done_i),
        .en_rx_o            (en_rx_o),
        .en_tx_o            (en_tx_o),
        .rx_irq_o           (rx_irq_o),
        .tx_irq_o           (tx_irq_o),
        .err_irq_o          (err_irq_o)
    );

    logic any_out;
    assign any_out = |{rx_saddr_o, tx_saddr_o, rx_size_o, tx_size_o, rx_cont_o, tx_cont_o,
                       rx_en_o, tx_en_o, rx_clr_o, tx_clr_o, en_rx_o, en_tx_o,
                       rx_irq_o, tx_irq_o, err_irq_o};

    // Each cycle starts 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b0;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        tick();
        cfg_valid_i = 1'b0;
        cfg_rwn_i   = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = a;
        #1;
        chk(tag, cfg_data_o, exp);
        cfg_valid_i = 1'b0;
    endtask

    initial begin
        // ---- 1: reset state ----
        tick();
        tick();
        rst = 1'b0;
        for (int a = 0; a < 64; a++) begin
            rd_chk($sformatf("reset_rd%0d", a), 6'(a), (a == 32) ? 32'h0000_02A5 : 32'h0);
        end
        chk("reset_outs", 32'(any_out), 32'h0);
        chk("ready", 32'(cfg_ready_o), 32'h1);

        // ---- 2: channel region ----
        wr(6'd13, 32'h11);                     // ch1 TX_CFG: en + continuous
        chk("tx_en_pulse", 32'(tx_en_o), 32'h2);
        chk("tx_cont", 32'(tx_cont_o), 32'h2);
        tick();
        chk("tx_en_drop", 32'(tx_en_o), 32'h0);
        rd_chk("tx_cfg_rd", 6'd13, 32'h1);
        tx_busy_i = 2'b10;
        rd_chk("status_busy", 6'd32, 32'h0000_22A5);
        wr(6'd13, 32'h11);
        chk("tx_en_busy", 32'(tx_en_o), 32'h0);
        tx_busy_i = 2'b00;
        wr(6'd16, 32'hABC);                    // ch2 does not exist
        wr(6'd18, 32'h11);
        chk("ch2_no_pulse", 32'(rx_en_o), 32'h0);
        chk("ch2_no_saddr", 32'(rx_saddr_o), 32'h0);
        rd_chk("ch2_rd", 6'd16, 32'h0);
        rd_chk("ch2_cfg_rd", 6'd18, 32'h0);
        wr(6'd0, 32'hFFFF_F123);
        chk("rx_saddr0", 32'(rx_saddr_o), 32'h0000_0123);
        wr(6'd9, 32'h0000_BEEF);
        chk("rx_size1", rx_size_o, 32'hBEEF_0000);
        rx_curr_i = 24'h456_789;
        rd_chk("rx_curr1", 6'd8, 32'h456);
        rx_pend_i = 2'b01;
        rd_chk("rx_cfg0_pend", 6'd2, 32'h20);
        rx_pend_i = 2'b00;
        wr(6'd2, 32'h50);                      // back-to-back: ch0 clr+en, ch1 en
        chk("b2b_en0", 32'(rx_en_o), 32'h1);
        chk("b2b_clr0", 32'(rx_clr_o), 32'h1);
        wr(6'd10, 32'h10);
        chk("b2b_en1", 32'(rx_en_o), 32'h2);
        chk("b2b_clr1", 32'(rx_clr_o), 32'h0);
        tick();
        chk("b2b_idle", 32'(rx_en_o), 32'h0);

        // ---- 3: error capture and interrupt ----
        wr(6'd35, 32'h2);
        err_i = 6'h04;
        tick();
        err_i = 6'h00;
        rd_chk("err_set", 6'd34, 32'h04);
        rd_chk("pend_err", 6'd36, 32'h2);
        chk("err_irq_t1", 32'(err_irq_o), 32'h0);
        tick();
        chk("err_irq_t2", 32'(err_irq_o), 32'h1);
        wr(6'd34, 32'h04);
        wr(6'd36, 32'h2);
        rd_chk("err_w1c", 6'd34, 32'h0);
        rd_chk("pend_w1c", 6'd36, 32'h0);
        tick();
        chk("err_irq_fall", 32'(err_irq_o), 32'h0);

        // rx interrupt, then drop it by clearing IRQ_EN
        wr(6'd35, 32'h1);
        rx_done_i = 1'b1;
        tick();
        rx_done_i = 1'b0;
        tick();
        chk("rx_irq_rise", 32'(rx_irq_o), 32'h1);
        wr(6'd35, 32'h0);
        tick();
        chk("rx_irq_dis", 32'(rx_irq_o), 32'h0);
        rd_chk("pend_kept", 6'd36, 32'h1);

        // ---- 4: event wins over coincident W1C ----
        err_i = 6'h01;
        wr(6'd34, 32'h01);
        err_i = 6'h00;
        rd_chk("err_set_wins", 6'd34, 32'h01);

        // ---- 5: saturating frame counter ----
        wr(6'd39, 32'h0);
        rd_chk("rxcnt_clr", 6'd39, 32'h0);
        rx_done_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        rx_done_i = 1'b0;
        rd_chk("rxcnt_sat", 6'd39, 32'd15);
        rx_done_i = 1'b1;
        wr(6'd39, 32'h0);
        rx_done_i = 1'b0;
        rd_chk("rxcnt_clr_done", 6'd39, 32'd1);
        tx_done_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tx_done_i = 1'b0;
        rd_chk("txcnt3", 6'd40, 32'd3);
        rd_chk("pend_frames", 6'd36, 32'h7);

        // ---- 6: reset during an active pulse ----
        wr(6'd33, 32'h300);
        chk("setup_en", 32'({en_rx_o, en_tx_o}), 32'h3);
        rd_chk("setup_rd", 6'd33, 32'h300);
        wr(6'd35, 32'h7);
        wr(6'd2, 32'h10);
        chk("pre_rst_pulse", 32'(rx_en_o), 32'h1);
        rst         = 1'b1;
        cfg_valid_i = 1'b1;                    // strobe during reset must be ignored
        cfg_rwn_i   = 1'b0;
        cfg_addr_i  = 6'd33;
        cfg_data_i  = 32'h300;
        tick();
        rst         = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_rwn_i   = 1'b1;
        chk("rst_pulse_drop", 32'(rx_en_o), 32'h0);
        chk("rst_outs", 32'(any_out), 32'h0);
        rd_chk("rst_setup", 6'd33, 32'h0);
        rd_chk("rst_err", 6'd34, 32'h0);
        rd_chk("rst_irqen", 6'd35, 32'h0);
        rd_chk("rst_pend", 6'd36, 32'h0);
        rd_chk("rst_rxcnt", 6'd39, 32'h0);
        rd_chk("rst_txcnt", 6'd40, 32'h0);
        rd_chk("rst_txcfg1", 6'd13, 32'h0);
        tick();
        chk("rst_irq", 32'({rx_irq_o, tx_irq_o, err_irq_o}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
